fetch_inflight_queue: RTL and testbench
=======================================

# fetch_inflight_queue

Parametrised in-order tracker for outstanding instruction-fetch requests. It sits between the fetch-request stage and the instruction-return stage in IF. It replaces the single-entry trace register with a DEPTH-entry circular queue, so the bus can hold up to DEPTH requests in flight. Each entry holds a packet's address, enables, merged exception status, cancel flag and an opaque prediction-metadata bundle until the matching `inst_data_ok` retires it.

## Interface
- `DEPTH`, 2: maximum outstanding fetch packets; must be ≥1 (any value, not only powers of two).
- `INST_NUM`, 4: instructions per fetch packet (enable-mask width).
- `VADDR_W`, 32: virtual-address width.
- `META_W`, 256: width of the opaque BPU metadata bundle (BTB/IJTC/RAS/PHT results, concatenated upstream).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `req_valid_i` in 1: upstream packet valid this cycle.
- `req_vaddr_i` in VADDR_W: packet virtual address.
- `req_enable_i` in INST_NUM: per-instruction enable mask.
- `req_has_exc_i` in 1: upstream exception already present.
- `req_exccode_i` in 5: upstream ExcCode.
- `req_canceled_i` in 1: packet already canceled upstream.
- `req_meta_i` in META_W: prediction metadata.
- `mmu_has_exc_i` in 1: MMU exception for this packet (same cycle as push).
- `mmu_exccode_i` in 5: MMU ExcCode.
- `mmu_is_refill_i` in 1: MMU exception is a TLB refill.
- `inst_data_ok` in 1: bus returns the oldest outstanding packet.
- `cancel_i` in 1: branch-redirect OR CP0 exception flush.
- `allowin_o` out 1: queue can accept a push this cycle.
- `out_valid_o` out 1: returned packet is live and must be consumed.
- `out_vaddr_o` out VADDR_W, `out_enable_o` out INST_NUM, `out_has_exc_o` out 1, `out_exccode_o` out 5, `out_is_refill_o` out 1, `out_meta_o` out META_W: head-entry fields.
- `count_o` out $clog2(DEPTH+1): number of resident entries.
- `proto_err_o` out 1: sticky protocol error (see Configuration).

## Operation
- Storage: DEPTH entries, plus a head pointer, a tail pointer and a count. Pointers wrap from DEPTH-1 to 0.
- allowin_o = (count < DEPTH) || inst_data_ok.
- Push (req_valid_i && allowin_o) writes the tail entry and advances tail. Fields are written as follows:
  - has_exc = req_has_exc_i | mmu_has_exc_i.
  - exccode = req_has_exc_i ? req_exccode_i : mmu_exccode_i.
  - is_refill = !req_has_exc_i & mmu_is_refill_i.
  - canceled = req_canceled_i | cancel_i.
  - vaddr, enable and meta are copied from the request.
- Pop (inst_data_ok && count>0) advances head.
- out_valid_o = inst_data_ok && count>0 && !head.canceled. The out_* fields always reflect the head entry combinationally.
- Cancel: when cancel_i is high, every resident entry not popped this cycle gets canceled=1. A push in the same cycle is also stored canceled. Canceled entries still wait for their data_ok; this drains the bus responses without delivering them.
- inst_data_ok with count==0 is ignored: no state change, out_valid_o=0.
- Push and pop in the same cycle: count is unchanged. This is legal when full, which is why allowin_o includes the inst_data_ok term.

## Timing
- Reset (rst==0 at posedge): head=tail=count=0 and all entries are zeroed, with exccode = `NOEXCCODE`.
  - Resulting outputs: allowin_o=1, out_valid_o=0, out_* = 0 (out_exccode_o = `NOEXCCODE`), count_o=0, proto_err_o=0.
  - Reset has priority over push, pop and cancel. A mid-operation reset discards all in-flight entries; responses arriving afterwards are treated as data_ok-while-empty.
- Push-to-head latency: an entry pushed at edge N is visible on out_* from cycle N+1. The earliest return is data_ok in cycle N+1.
- cancel_i is sampled at the edge. It does not mask out_valid_o in the same cycle; the popped head is delivered if it was not already canceled.
- No combinational path from inst_data_ok to state other than through allowin_o and out_valid_o.

## Configuration
- `FIQ_PROTO_CHECK_EN` defined: proto_err_o is set sticky (cleared only by reset) in either case:
  - inst_data_ok && count==0;
  - req_valid_i && !allowin_o.
  In both cases the offending event is still ignored.
- Undefined: proto_err_o is tied to 0 and the checker logic is absent.

## Test plan
- DEPTH=2. Push A (0x1000), push B (0x1010), data_ok, data_ok → out_valid_o=1 with out_vaddr_o=0x1000, then 0x1010; count_o goes 1,2,1,0.
- Full queue (count=2) with req_valid_i and inst_data_ok high together → push accepted, head pops, count_o stays 2, allowin_o=1.
- Two entries resident, cancel_i pulsed once, then two data_ok → out_valid_o=0 both times; count_o reaches 0; a subsequent push and data_ok delivers out_valid_o=1.
- Push with req_has_exc_i=0, mmu_has_exc_i=1, mmu_exccode_i=3, mmu_is_refill_i=1 → out_has_exc_o=1, out_exccode_o=3, out_is_refill_o=1. Repeat with req_has_exc_i=1, req_exccode_i=4 → out_exccode_o=4, out_is_refill_o=0.
- Assert rst=0 with 2 entries resident → count_o=0, out_valid_o=0, allowin_o=1 on the next cycle. A later data_ok is ignored, and proto_err_o=1 only when the macro is defined.
- DEPTH=3, 7 push/pop pairs → pointer wrap; FIFO order preserved and out_meta_o matches pushed metadata.

Source files
------------

// File: rtl/fetch_inflight_queue.sv
// fetch_inflight_queue
//
// In-order tracker for outstanding instruction-fetch requests, sitting
// between the fetch-request stage and the instruction-return stage of IF.
// A DEPTH-entry circular queue holds one record per packet on the bus:
// address, enable mask, merged exception status, cancel flag and an
// opaque BPU metadata bundle. Each record stays resident until the
// matching inst_data_ok retires it.
//
// Optional feature: define FIQ_PROTO_CHECK_EN to build the sticky
// protocol checker behind proto_err_o. Without it proto_err_o is tied
// low and the checker logic is absent.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_*               upstream fetch packet, pushed when req_valid_i && allowin_o
//   mmu_*               MMU exception result for the packet being pushed
//   inst_data_ok        bus return for the oldest outstanding packet
//   cancel_i            redirect/flush: cancels every resident entry
//   allowin_o           queue can accept a push this cycle
//   out_valid_o         returned packet is live and must be consumed
//   out_*               head-entry fields (combinational view of the head)
//   count_o             number of resident entries
//   proto_err_o         sticky protocol error (0 when the checker is absent)

`ifndef NOEXCCODE
`define NOEXCCODE 5'h1f
`endif

module fetch_inflight_queue #(
  parameter int DEPTH    = 2,
  parameter int INST_NUM = 4,
  parameter int VADDR_W  = 32,
  parameter int META_W   = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  input  logic [VADDR_W-1:0]         req_vaddr_i,
  input  logic [INST_NUM-1:0]        req_enable_i,
  input  logic                       req_has_exc_i,
  input  logic [4:0]                 req_exccode_i,
  input  logic                       req_canceled_i,
  input  logic [META_W-1:0]          req_meta_i,
  input  logic                       mmu_has_exc_i,
  input  logic [4:0]                 mmu_exccode_i,
  input  logic                       mmu_is_refill_i,
  input  logic                       inst_data_ok,
  input  logic                       cancel_i,
  output logic                       allowin_o,
  output logic                       out_valid_o,
  output logic [VADDR_W-1:0]         out_vaddr_o,
  output logic [INST_NUM-1:0]        out_enable_o,
  output logic                       out_has_exc_o,
  output logic [4:0]                 out_exccode_o,
  output logic                       out_is_refill_o,
  output logic [META_W-1:0]          out_meta_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       proto_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [CNT_W-1:0]    count_q;

  logic [VADDR_W-1:0]  vaddr_q    [DEPTH];
  logic [INST_NUM-1:0] enable_q   [DEPTH];
  logic                has_exc_q  [DEPTH];
  logic [4:0]          exccode_q  [DEPTH];
  logic                refill_q   [DEPTH];
  logic                canceled_q [DEPTH];
  logic [META_W-1:0]   meta_q     [DEPTH];

  logic push;
  logic pop;
  logic not_empty;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full queue still accepts a push when the head retires in the same
  // cycle, so allowin includes inst_data_ok.
  always_comb begin
    not_empty = (count_q != '0);
    allowin_o = (count_q < CNT_W'(DEPTH)) || inst_data_ok;
    push      = req_valid_i && allowin_o;
    pop       = inst_data_ok && not_empty;
  end

  // Queue storage and pointers. Cancel marks every slot first; a push in
  // the same cycle then overwrites the tail with its own canceled value,
  // which also includes cancel_i. Marking free slots is harmless because
  // a push always rewrites the flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vaddr_q[i]    <= '0;
        enable_q[i]   <= '0;
        has_exc_q[i]  <= 1'b0;
        exccode_q[i]  <= `NOEXCCODE;
        refill_q[i]   <= 1'b0;
        canceled_q[i] <= 1'b0;
        meta_q[i]     <= '0;
      end
    end else begin
      if (cancel_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          canceled_q[i] <= 1'b1;
        end
      end
      if (push) begin
        vaddr_q[tail_q]    <= req_vaddr_i;
        enable_q[tail_q]   <= req_enable_i;
        has_exc_q[tail_q]  <= req_has_exc_i | mmu_has_exc_i;
        exccode_q[tail_q]  <= req_has_exc_i ? req_exccode_i : mmu_exccode_i;
        refill_q[tail_q]   <= !req_has_exc_i & mmu_is_refill_i;
        canceled_q[tail_q] <= req_canceled_i | cancel_i;
        meta_q[tail_q]     <= req_meta_i;
        tail_q             <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Head view. cancel_i is only sampled at the edge, so it never masks
  // the packet being delivered in the current cycle.
  always_comb begin
    out_valid_o     = pop && !canceled_q[head_q];
    out_vaddr_o     = vaddr_q[head_q];
    out_enable_o    = enable_q[head_q];
    out_has_exc_o   = has_exc_q[head_q];
    out_exccode_o   = exccode_q[head_q];
    out_is_refill_o = refill_q[head_q];
    out_meta_o      = meta_q[head_q];
    count_o         = count_q;
  end

`ifdef FIQ_PROTO_CHECK_EN
  logic proto_err_q;

  // Sticky flag for a return with nothing outstanding or a push refused
  // by backpressure; the offending event itself is still ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      proto_err_q <= 1'b0;
    end else if ((inst_data_ok && !not_empty) || (req_valid_i && !allowin_o)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_inflight_queue.sv
// Testbench for fetch_inflight_queue.
// Two instances (DEPTH=2 and DEPTH=3) share the same stimulus; a monitor
// checks whichever instance is selected against a scoreboard of
// hand-written expected packets.

`timescale 1ns/1ps

`ifndef NOEXCCODE
`define NOEXCCODE 5'h1f
`endif

module tb_fetch_inflight_queue;

  typedef struct {
    logic [31:0]  vaddr;
    logic [3:0]   en;
    logic         has_exc;
    logic [4:0]   exccode;
    logic         refill;
    logic [255:0] meta;
  } pkt_t;

  logic         clk;
  logic         rst;
  logic         req_valid_i;
  logic [31:0]  req_vaddr_i;
  logic [3:0]   req_enable_i;
  logic         req_has_exc_i;
  logic [4:0]   req_exccode_i;
  logic         req_canceled_i;
  logic [255:0] req_meta_i;
  logic         mmu_has_exc_i;
  logic [4:0]   mmu_exccode_i;
  logic         mmu_is_refill_i;
  logic         inst_data_ok;
  logic         cancel_i;

  logic         allowin2, valid2, has_exc2, refill2, perr2;
  logic [31:0]  vaddr2;
  logic [3:0]   en2;
  logic [4:0]   exc2;
  logic [255:0] meta2;
  logic [1:0]   count2;

  logic         allowin3, valid3, has_exc3, refill3, perr3;
  logic [31:0]  vaddr3;
  logic [3:0]   en3;
  logic [4:0]   exc3;
  logic [255:0] meta3;
  logic [1:0]   count3;

  logic         sel3;
  logic         mon_valid;
  logic         mon_allowin;
  logic [1:0]   mon_count;

  int total;
  int bad;
  pkt_t sb[$];

  fetch_inflight_queue #(.DEPTH(2), .INST_NUM(4), .VADDR_W(32), .META_W(256)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_enable_i(req_enable_i),
    .req_has_exc_i(req_has_exc_i), .req_exccode_i(req_exccode_i),
    .req_canceled_i(req_canceled_i), .req_meta_i(req_meta_i),
    .mmu_has_exc_i(mmu_has_exc_i), .mmu_exccode_i(mmu_exccode_i),
    .mmu_is_refill_i(mmu_is_refill_i), .inst_data_ok(inst_data_ok), .cancel_i(cancel_i),
    .allowin_o(allowin2), .out_valid_o(valid2), .out_vaddr_o(vaddr2),
    .out_enable_o(en2), .out_has_exc_o(has_exc2), .out_exccode_o(exc2),
    .out_is_refill_o(refill2), .out_meta_o(meta2), .count_o(count2),
    .proto_err_o(perr2)
  );

  fetch_inflight_queue #(.DEPTH(3), .INST_NUM(4), .VADDR_W(32), .META_W(256)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_enable_i(req_enable_i),
    .req_has_exc_i(req_has_exc_i), .req_exccode_i(req_exccode_i),
    .req_canceled_i(req_canceled_i), .req_meta_i(req_meta_i),
    .mmu_has_exc_i(mmu_has_exc_i), .mmu_exccode_i(mmu_exccode_i),
    .mmu_is_refill_i(mmu_is_refill_i), .inst_data_ok(inst_data_ok), .cancel_i(cancel_i),
    .allowin_o(allowin3), .out_valid_o(valid3), .out_vaddr_o(vaddr3),
    .out_enable_o(en3), .out_has_exc_o(has_exc3), .out_exccode_o(exc3),
    .out_is_refill_o(refill3), .out_meta_o(meta3), .count_o(count3),
    .proto_err_o(perr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mon_valid   = sel3 ? valid3   : valid2;
  assign mon_allowin = sel3 ? allowin3 : allowin2;
  assign mon_count   = sel3 ? count3   : count2;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered packet must match the oldest expected one.
  always @(negedge clk) begin
    pkt_t e;
    if (rst && mon_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got vaddr %0h expected no delivery",
                 sel3 ? vaddr3 : vaddr2);
      end else begin
        e = sb.pop_front();
        checkOutput("out_vaddr",   sel3 ? vaddr3 : vaddr2, e.vaddr);
        checkOutput("out_enable",  sel3 ? en3 : en2, e.en);
        checkOutput("out_has_exc", sel3 ? has_exc3 : has_exc2, e.has_exc);
        checkOutput("out_exccode", sel3 ? exc3 : exc2, e.exccode);
        checkOutput("out_refill",  sel3 ? refill3 : refill2, e.refill);
        checkOutput("out_meta",    sel3 ? meta3 : meta2, e.meta);
      end
    end
  end

  task automatic clearInputs();
    req_valid_i     = 1'b0;
    req_vaddr_i     = '0;
    req_enable_i    = '0;
    req_has_exc_i   = 1'b0;
    req_exccode_i   = '0;
    req_canceled_i  = 1'b0;
    req_meta_i      = '0;
    mmu_has_exc_i   = 1'b0;
    mmu_exccode_i   = '0;
    mmu_is_refill_i = 1'b0;
    inst_data_ok    = 1'b0;
    cancel_i        = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [3:0] en,
                               input logic [255:0] meta, input logic dok, input logic cxl);
    req_valid_i  = v;
    req_vaddr_i  = a;
    req_enable_i = en;
    req_meta_i   = meta;
    inst_data_ok = dok;
    cancel_i     = cxl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic expectPkt(input logic [31:0] a, input logic [3:0] en, input logic he,
                           input logic [4:0] ec, input logic rf, input logic [255:0] meta);
    pkt_t p;
    p.vaddr = a; p.en = en; p.has_exc = he; p.exccode = ec; p.refill = rf; p.meta = meta;
    sb.push_back(p);
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel3  = 1'b0;
    rst   = 1'b0;
    clearInputs();
    doReset();

    // Reset state
    checkOutput("rst_count",   count2, 0);
    checkOutput("rst_allowin", allowin2, 1);
    checkOutput("rst_valid",   valid2, 0);
    checkOutput("rst_vaddr",   vaddr2, 0);
    checkOutput("rst_exccode", exc2, `NOEXCCODE);
    checkOutput("rst_perr",    perr2, 0);

    // Basic in-order return: A then B
    applyStimulus(1, 32'h1000, 4'hF, 256'hA1, 0, 0); tick();
    checkOutput("ab_count1", count2, 1);
    checkOutput("ab_head",   vaddr2, 32'h1000);
    applyStimulus(1, 32'h1010, 4'h7, 256'hB2, 0, 0); tick();
    checkOutput("ab_count2", count2, 2);
    checkOutput("ab_full_allowin", allowin2, 0);
    expectPkt(32'h1000, 4'hF, 0, 5'd0, 0, 256'hA1);
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    checkOutput("ab_count3", count2, 1);
    expectPkt(32'h1010, 4'h7, 0, 5'd0, 0, 256'hB2);
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    checkOutput("ab_count4", count2, 0);

    // Full queue with simultaneous push and pop
    applyStimulus(1, 32'h2000, 4'h1, 256'hC3, 0, 0); tick();
    applyStimulus(1, 32'h2010, 4'h3, 256'hD4, 0, 0); tick();
    expectPkt(32'h2000, 4'h1, 0, 5'd0, 0, 256'hC3);
    applyStimulus(1, 32'h2020, 4'h8, 256'hE5, 1, 0);
    #1;
    checkOutput("full_pp_allowin", allowin2, 1);
    tick();
    checkOutput("full_pp_count", count2, 2);
    expectPkt(32'h2010, 4'h3, 0, 5'd0, 0, 256'hD4);
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    expectPkt(32'h2020, 4'h8, 0, 5'd0, 0, 256'hE5);
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    checkOutput("full_pp_drain", count2, 0);

    // Cancel with two resident: both drained silently
    applyStimulus(1, 32'h3000, 4'hF, 256'h11, 0, 0); tick();
    applyStimulus(1, 32'h3010, 4'hF, 256'h22, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 1); tick();
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    checkOutput("cxl_count", count2, 0);
    expectPkt(32'h3020, 4'h5, 0, 5'd0, 0, 256'h33);
    applyStimulus(1, 32'h3020, 4'h5, 256'h33, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 1, 0); tick();

    // Cancel in the same cycle as a pop: popped head still delivered
    applyStimulus(1, 32'h3100, 4'hF, 256'h44, 0, 0); tick();
    applyStimulus(1, 32'h3110, 4'hF, 256'h55, 0, 0); tick();
    expectPkt(32'h3100, 4'hF, 0, 5'd0, 0, 256'h44);
    applyStimulus(0, 0, 0, 0, 1, 1); tick();
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    checkOutput("cxl_pop_count", count2, 0);

    // Upstream-canceled push is never delivered
    req_canceled_i = 1'b1;
    applyStimulus(1, 32'h3200, 4'hF, 256'h66, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 1, 0); tick();

    // Exception merge: MMU only, then upstream wins
    mmu_has_exc_i = 1'b1; mmu_exccode_i = 5'd3; mmu_is_refill_i = 1'b1;
    applyStimulus(1, 32'h4000, 4'h2, 256'h77, 0, 0); tick();
    checkOutput("exc_mmu_head", exc2, 5'd3);
    expectPkt(32'h4000, 4'h2, 1, 5'd3, 1, 256'h77);
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    req_has_exc_i = 1'b1; req_exccode_i = 5'd4;
    mmu_has_exc_i = 1'b1; mmu_exccode_i = 5'd3; mmu_is_refill_i = 1'b1;
    applyStimulus(1, 32'h4010, 4'h4, 256'h88, 0, 0); tick();
    expectPkt(32'h4010, 4'h4, 1, 5'd4, 0, 256'h88);
    applyStimulus(0, 0, 0, 0, 1, 0); tick();

    // Reset with two entries resident, then a stray return
    applyStimulus(1, 32'h5000, 4'hF, 256'h99, 0, 0); tick();
    applyStimulus(1, 32'h5010, 4'hF, 256'hAA, 0, 0); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    checkOutput("mrst_count",   count2, 0);
    checkOutput("mrst_allowin", allowin2, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("mrst_valid", valid2, 0);
    tick();
    checkOutput("mrst_count2", count2, 0);
`ifdef FIQ_PROTO_CHECK_EN
    checkOutput("mrst_perr", perr2, 1);
`else
    checkOutput("mrst_perr", perr2, 0);
`endif

    // DEPTH=3 pointer wrap with 7 push/pop pairs
    sel3 = 1'b1;
    doReset();
    checkOutput("d3_rst_count", count3, 0);
    applyStimulus(1, 32'h6000, 4'h1, {8{32'hC0DE0000}}, 0, 0); tick();
    applyStimulus(1, 32'h6010, 4'h2, {8{32'hC0DE0001}}, 0, 0); tick();
    for (int i = 2; i < 9; i++) begin
      expectPkt(32'h6000 + 32'((i - 2) * 16), 4'(i - 1), 0, 5'd0, 0, {8{32'hC0DE0000 + 32'(i - 2)}});
      applyStimulus(1, 32'h6000 + 32'(i * 16), 4'(i + 1), {8{32'hC0DE0000 + 32'(i)}}, 1, 0);
      tick();
    end
    checkOutput("d3_pairs_count", mon_count, 2);
    checkOutput("d3_pairs_allowin", mon_allowin, 1);
    expectPkt(32'h6070, 4'h8, 0, 5'd0, 0, {8{32'hC0DE0007}});
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    expectPkt(32'h6080, 4'h9, 0, 5'd0, 0, {8{32'hC0DE0008}});
    applyStimulus(0, 0, 0, 0, 1, 0); tick();
    checkOutput("d3_drain_count", count3, 0);

    @(posedge clk);
    checkOutput("sb_empty", 256'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
